codificador_led_secuencial: RTL and testbench
=============================================

Name: codificador_led_secuencial

Overview:
Parametrised, clocked successor to the combinational result-to-LED decoder in the LED game. It accepts a 2-bit result code with a valid strobe and drives the red, green and end LEDs. Red/green codes blink a programmable number of times before holding steady. The end code lights all LEDs. The block sits between the game controller (which emits the result code) and the board LED pins, and reports busy/done back to the controller.

Parameters:
CLK_DIV, 25000000, clock cycles per blink half-period (on phase or off phase); legal range >= 1
N_PARPADEOS, 3, number of on/off blink pairs before steady hold; legal range >= 1
FIN_PARPADEA, 0, 0: end code lights all LEDs steady; 1: all LEDs blink continuously at the CLK_DIV rate

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
numero  in  2  result code: 0=off, 1=red (miss), 2=green (hit), 3=end of game
valido  in  1  numero is valid this cycle; sampled on the rising edge of clk
ocupado  out  1  high while blinking; valido is ignored while high
listo  out  1  single-cycle pulse when a red/green blink sequence completes
LedRojo  out  1  red LED, active high
LedVerde  out  1  green LED, active high
LedFin  out  1  end LED, active high

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=REPOSO; all LEDs, ocupado and listo = 0.
  - Divider counter and blink counter = 0.
  - Asserting reset mid-sequence aborts the sequence immediately.
- States: REPOSO, PARPADEO, MANTENER, FIN.
- Acceptance:
  - valido=1 is accepted in REPOSO, MANTENER and FIN; it is ignored in PARPADEO.
  - numero is latched on the accepting edge. Outputs change on that same edge, so latency is 1 clock from valido sampled to the LED update.
- Code 0: go to REPOSO; all LEDs off.
- Code 1 or 2:
  - Go to PARPADEO. The selected LED (1=LedRojo, 2=LedVerde) turns on; all other LEDs are off.
  - ocupado=1; divider counter=0; blink counter=0.
- PARPADEO:
  - The divider counts 0..CLK_DIV-1. At terminal count the selected LED toggles and the divider returns to 0.
  - Each on->off->on transition increments the blink counter.
  - When the N_PARPADEOS-th off phase ends, go to MANTENER. The selected LED is on steady, ocupado=0 and listo=1 for exactly one cycle.
  - Total PARPADEO duration is exactly 2*N_PARPADEOS*CLK_DIV cycles after the accepting edge.
- MANTENER: the selected LED stays on until the next accepted valido or reset.
- Code 3:
  - Go to FIN with all three LEDs on; ocupado=0; no listo pulse.
  - If FIN_PARPADEA=1, all three LEDs toggle together every CLK_DIV cycles, starting on, indefinitely.
  - Leaving FIN requires an accepted valido or reset.
- Same code re-issued in MANTENER: the blink sequence restarts from the beginning.
- Width rules:
  - Divider width = max(1, clog2(CLK_DIV)).
  - Blink counter width = max(1, clog2(N_PARPADEOS+1)).
  - Counters never wrap within a sequence.
- CLK_DIV=1: LED toggles every cycle; the same timing formula holds.
- Simultaneous events:
  - valido on the same edge as PARPADEO completes: ignored, because the state is still PARPADEO on that edge. listo still pulses.
  - rst_n takes priority over everything.
- numero is only sampled when valido=1. LEDs never depend combinationally on numero.

Test Plan:
- Reset: hold rst_n=0 with valido=1, numero=3 -> all outputs 0. Deassert -> outputs stay 0 until valido.
- CLK_DIV=4, N_PARPADEOS=2; valido with numero=2 at edge k:
  - LedVerde=1 for edges k..k+3, 0 for k+4..k+7, 1 for k+8..k+11, 0 for k+12..k+15.
  - At edge k+16: LedVerde=1 steady, listo=1 for one cycle, ocupado=0.
  - LedRojo=LedFin=0 throughout.
- During the numero=1 sequence, pulse valido with numero=3 at k+5 -> ignored; red sequence completes unchanged.
- In MANTENER, valido with numero=3 -> next edge all LEDs =1, no listo. Then valido with numero=0 -> all LEDs 0.
- FIN_PARPADEA=1, CLK_DIV=4; numero=3 -> all LEDs high 4 cycles, low 4 cycles, repeating for at least 3 periods.
- Mid-blink at k+6, pulse rst_n=0 between clock edges -> outputs 0 immediately. A new valido with numero=1 restarts with full timing.

Source files
------------

// File: rtl/codificador_led_secuencial.sv
// Clocked result-to-LED encoder for the LED game.
// A red/green result blinks N_PARPADEOS on/off pairs of CLK_DIV cycles each,
// then holds steady. The end code lights all three LEDs, steady or blinking.
// All outputs are decoded from registers only; numero never reaches the LEDs
// combinationally.
module codificador_led_secuencial #(
  parameter int CLK_DIV      = 25000000,
  parameter int N_PARPADEOS  = 3,
  parameter int FIN_PARPADEA = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] numero,
  input  logic       valido,
  output logic       ocupado,
  output logic       listo,
  output logic       LedRojo,
  output logic       LedVerde,
  output logic       LedFin
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = ($clog2(N_PARPADEOS + 1) > 1) ? $clog2(N_PARPADEOS + 1) : 1;

  // Terminal divider count and the blink index of the last off phase.
  localparam logic [DIV_W-1:0] DIV_FIN   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ULT   = CNT_W'(N_PARPADEOS - 1);
  localparam bit               FIN_BLINK = (FIN_PARPADEA != 0);

  typedef enum logic [1:0] {
    REPOSO,
    PARPADEO,
    MANTENER,
    FIN
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_verde_q, sel_verde_d;  // 1: green selected, 0: red
  logic             fase_q, fase_d;            // current lit/dark phase
  logic             listo_q, listo_d;

  // State and datapath registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= REPOSO;
      div_q       <= '0;
      cnt_q       <= '0;
      sel_verde_q <= 1'b0;
      fase_q      <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      sel_verde_q <= sel_verde_d;
      fase_q      <= fase_d;
      listo_q     <= listo_d;
    end
  end

  // Next-state: divider/blink progress first, then acceptance of a new code.
  always_comb begin
    estado_d    = estado_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    sel_verde_d = sel_verde_q;
    fase_d      = fase_q;
    listo_d     = 1'b0;

    case (estado_q)
      PARPADEO: begin
        if (div_q == DIV_FIN) begin
          div_d = '0;
          if (fase_q) begin
            fase_d = 1'b0;
          end else if (cnt_q == CNT_ULT) begin
            // Last off phase ended: settle on steady light.
            estado_d = MANTENER;
            fase_d   = 1'b1;
            listo_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            fase_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      FIN: begin
        if (FIN_BLINK) begin
          if (div_q == DIV_FIN) begin
            div_d  = '0;
            fase_d = ~fase_q;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: begin
      end
    endcase

    // A new code is only taken when no blink sequence is running.
    if (valido && (estado_q != PARPADEO)) begin
      div_d = '0;
      cnt_d = '0;
      case (numero)
        2'd0: begin
          estado_d = REPOSO;
          fase_d   = 1'b0;
        end
        2'd3: begin
          estado_d = FIN;
          fase_d   = 1'b1;
        end
        default: begin
          estado_d    = PARPADEO;
          sel_verde_d = numero[1];
          fase_d      = 1'b1;
        end
      endcase
    end
  end

  logic modo_color;
  logic modo_fin;

  // Output decode from registered state only.
  always_comb begin
    modo_color = (estado_q == PARPADEO) || (estado_q == MANTENER);
    modo_fin   = (estado_q == FIN);
    ocupado    = (estado_q == PARPADEO);
    listo      = listo_q;
    LedRojo    = fase_q && ((modo_color && !sel_verde_q) || modo_fin);
    LedVerde   = fase_q && ((modo_color && sel_verde_q) || modo_fin);
    LedFin     = fase_q && modo_fin;
  end

endmodule

// File: tb/tb_codificador_led_secuencial.sv
// Randomized and directed bench for codificador_led_secuencial.
// Three instances share the same inputs: CLK_DIV=4/N=2 steady end,
// CLK_DIV=4/N=2 blinking end, and CLK_DIV=1/N=3 steady end. A timeline
// model (cycles elapsed since the accepting edge) predicts every output.
module tb_codificador_led_secuencial;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] numero;
  logic       valido;

  logic       ocu0, lis0, roj0, ver0, fin0;
  logic       ocu1, lis1, roj1, ver1, fin1;
  logic       ocu2, lis2, roj2, ver2, fin2;

  int nvec;
  int nerr;

  // Model parameters per instance.
  int pc [NI];
  int pn [NI];
  int pf [NI];

  // Model state: 0 idle, 1 blinking, 2 holding, 3 end.
  int   modo  [NI];
  int   t     [NI];
  logic verde [NI];
  logic lst   [NI];

  codificador_led_secuencial #(.CLK_DIV(4), .N_PARPADEOS(2), .FIN_PARPADEA(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .numero(numero), .valido(valido),
    .ocupado(ocu0), .listo(lis0), .LedRojo(roj0), .LedVerde(ver0), .LedFin(fin0)
  );

  codificador_led_secuencial #(.CLK_DIV(4), .N_PARPADEOS(2), .FIN_PARPADEA(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .numero(numero), .valido(valido),
    .ocupado(ocu1), .listo(lis1), .LedRojo(roj1), .LedVerde(ver1), .LedFin(fin1)
  );

  codificador_led_secuencial #(.CLK_DIV(1), .N_PARPADEOS(3), .FIN_PARPADEA(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .numero(numero), .valido(valido),
    .ocupado(ocu2), .listo(lis2), .LedRojo(roj2), .LedVerde(ver2), .LedFin(fin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] observado(input int i);
    case (i)
      0:       return {ocu0, lis0, roj0, ver0, fin0};
      1:       return {ocu1, lis1, roj1, ver1, fin1};
      default: return {ocu2, lis2, roj2, ver2, fin2};
    endcase
  endfunction

  function automatic logic [4:0] esperado(input int i);
    logic lit, r, g, f;
    lit = 1'b0;
    case (modo[i])
      1:       lit = ((t[i] / pc[i]) % 2) == 0;
      2:       lit = 1'b1;
      3:       lit = (pf[i] != 0) ? (((t[i] / pc[i]) % 2) == 0) : 1'b1;
      default: lit = 1'b0;
    endcase
    r = lit && (modo[i] == 3 || ((modo[i] == 1 || modo[i] == 2) && !verde[i]));
    g = lit && (modo[i] == 3 || ((modo[i] == 1 || modo[i] == 2) && verde[i]));
    f = lit && (modo[i] == 3);
    return {(modo[i] == 1), lst[i], r, g, f};
  endfunction

  task automatic comprobar(input string etq, input logic [4:0] obs, input logic [4:0] esp);
    nvec++;
    if (obs !== esp) begin
      nerr++;
      $display("FAIL %s @%0t: {ocupado,listo,rojo,verde,fin} got %b expected %b",
               etq, $time, obs, esp);
    end
  endtask

  task automatic comprobar_todos(input string etq);
    for (int i = 0; i < NI; i++)
      comprobar($sformatf("%s/dut%0d", etq, i), observado(i), esperado(i));
  endtask

  task automatic modelo_reset();
    for (int i = 0; i < NI; i++) begin
      modo[i]  = 0;
      t[i]     = 0;
      verde[i] = 1'b0;
      lst[i]   = 1'b0;
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic modelo_paso(input logic v, input logic [1:0] num);
    for (int i = 0; i < NI; i++) begin
      lst[i] = 1'b0;
      if (v && modo[i] != 1) begin
        t[i] = 0;
        case (num)
          2'd0:    modo[i] = 0;
          2'd3:    modo[i] = 3;
          default: begin
            modo[i]  = 1;
            verde[i] = (num == 2'd2);
          end
        endcase
      end else begin
        t[i]++;
        if (modo[i] == 1 && t[i] == 2 * pn[i] * pc[i]) begin
          modo[i] = 2;
          lst[i]  = 1'b1;
        end
      end
    end
  endtask

  task automatic ciclo(input logic v, input logic [1:0] num, input string etq);
    @(negedge clk);
    valido = v;
    numero = num;
    @(posedge clk);
    modelo_paso(v, num);
    #1;
    comprobar_todos(etq);
  endtask

  task automatic espera(input int n, input string etq);
    for (int k = 0; k < n; k++) ciclo(1'b0, 2'd0, etq);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulso_reset();
    @(negedge clk);
    valido = 1'b0;
    rst_n  = 1'b0;
    #1;
    modelo_reset();
    comprobar_todos("rst_async");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    modelo_paso(1'b0, 2'd0);
    #1;
    comprobar_todos("post_rst");
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    pc = '{4, 4, 1};
    pn = '{2, 2, 3};
    pf = '{0, 1, 0};
    modelo_reset();

    // Reset held with an end code pending on the inputs.
    rst_n  = 1'b0;
    valido = 1'b1;
    numero = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      comprobar_todos("reset");
    end
    @(negedge clk);
    rst_n  = 1'b1;
    valido = 1'b0;
    numero = 2'd0;
    espera(3, "idle");

    // Green sequence through to steady hold.
    ciclo(1'b1, 2'd2, "verde_acc");
    espera(20, "verde");

    // Red sequence with an end code pulsed at k+5 (ignored while blinking).
    ciclo(1'b1, 2'd1, "rojo_acc");
    espera(4, "rojo");
    ciclo(1'b1, 2'd3, "rojo_ign");
    espera(14, "rojo");

    // End code from hold, watched for several blink periods, then clear.
    ciclo(1'b1, 2'd3, "fin_acc");
    espera(26, "fin");
    ciclo(1'b1, 2'd0, "apagar");
    espera(2, "apagado");

    // Same code re-issued from hold restarts the sequence.
    ciclo(1'b1, 2'd2, "verde2");
    espera(18, "verde2");
    ciclo(1'b1, 2'd2, "verde_rep");
    espera(18, "verde_rep");

    // Reset mid-blink, then a fresh red sequence with full timing.
    ciclo(1'b1, 2'd1, "rojo2");
    espera(5, "rojo2");
    pulso_reset();
    ciclo(1'b1, 2'd1, "rojo3");
    espera(18, "rojo3");

    // Code offered on the very edge a 4x2 sequence completes.
    ciclo(1'b1, 2'd2, "borde_acc");
    espera(15, "borde");
    ciclo(1'b1, 2'd3, "borde_fin");
    espera(4, "borde_post");

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      ciclo(($urandom % 6) == 0, 2'($urandom % 4), "rand");
      if (($urandom % 150) == 0) pulso_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
